// File: rtl/seg_timer_display_pkg.sv
// Shared types and constants for the seven-segment timer display.
// Segment order is {g,f,e,d,c,b,a}; segments and anodes are active-low.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_OFF = 4'b1111;

  function automatic logic [6:0] digit_to_seg(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_timer_display_if.sv
// Count bus from the game timer plus the board-pin display outputs.
// master = timer/board side, slave = the display block.
interface seg_timer_display_if;

  logic [4:0] count_in;
  logic       game_start;
  logic       game_on;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (
    output count_in,
    output game_start,
    output game_on,
    input  seg,
    input  an,
    input  dp
  );

  modport slave (
    input  count_in,
    input  game_start,
    input  game_on,
    output seg,
    output an,
    output dp
  );

endinterface

// File: rtl/seg_timer_display_bin2bcd.sv
// Sequential shift-add-3 converter: 5-bit binary to two BCD digits.
// One load cycle, five shift cycles, one DONE cycle that updates ones/tens.
module seg_bin2bcd_seq
  import seg_disp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  bcd_state_e  state_q, state_d;
  logic [12:0] shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [12:0] adj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ones_q  <= '0;
      tens_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    adj     = shift_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {8'b0, bin};
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // a hundreds nibble is never needed: max input 31
        if (adj[8:5] >= 4'd5)
          adj[8:5] = adj[8:5] + 4'd3;
        if (adj[12:9] >= 4'd5)
          adj[12:9] = adj[12:9] + 4'd3;
        shift_d = {adj[11:0], 1'b0};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd4)
          state_d = DONE;
      end
      DONE: begin
        ones_d  = shift_q[8:5];
        tens_d  = shift_q[12:9];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign ones = ones_q;
  assign tens = tens_q;

endmodule

// File: rtl/seg_timer_display.sv
// Game-timer count to Basys 3 four-digit seven-segment display.
// Optional SEG_BLINK_EN: blink all anodes while the game is paused/over.
module seg_timer_display
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS   = 26
) (
  input  logic                clk,
  input  logic                reset,
  seg_timer_display_if.slave  bus
);

  logic [4:0]              last_val_q, last_val_d;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic [1:0]              sel;
  logic                    start;
  logic                    busy;
  logic                    bcd_done_unused;
  logic [3:0]              ones;
  logic [3:0]              tens;

  // changes during a conversion are picked up once back in IDLE
  assign start      = (bus.count_in != last_val_q) && !busy;
  assign last_val_d = start ? bus.count_in : last_val_q;

  seg_bin2bcd_seq u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bus.count_in),
    .busy  (busy),
    .done  (bcd_done_unused),
    .ones  (ones),
    .tens  (tens)
  );

  assign sel = refresh_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    case (sel)
      2'd0: begin
        an_d  = AN_D0;
        seg_d = digit_to_seg(ones);
      end
      2'd1: begin
        an_d  = AN_D1;
        seg_d = (tens == 4'd0) ? SEG_BLANK
                               : digit_to_seg(tens);
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_val_q <= '0;
      refresh_q  <= '0;
      seg_q      <= SEG_BLANK;
      an_q       <= AN_OFF;
    end else begin
      last_val_q <= last_val_d;
      refresh_q  <= refresh_q + REFRESH_BITS'(1);
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.dp  = 1'b1;

`ifdef SEG_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q;

  always_ff @(posedge clk) begin
    if (reset)
      blink_q <= '0;
    else
      blink_q <= blink_q + BLINK_BITS'(1);
  end

  assign bus.an = (bus.game_start && !bus.game_on &&
                   blink_q[BLINK_BITS-1]) ? AN_OFF : an_q;
`else
  localparam int unused_blink_bits = BLINK_BITS;
  logic unused_game;

  assign unused_game = bus.game_start ^ bus.game_on;
  assign bus.an      = an_q;
`endif

endmodule

// File: tb/tb_seg_timer_display.sv
// Self-checking bench for seg_timer_display with a short refresh counter.
// Expected display digits are queued at stimulus time and popped per scan.
module tb_seg_timer_display;

  logic clk;
  logic reset;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [6:0] so;
    logic [6:0] st;
  } exp_t;

  exp_t sb[$];

  seg_timer_display_if bus ();

  seg_timer_display #(
    .REFRESH_BITS (4),
    .BLINK_BITS   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic push_exp(input int v);
    exp_t e;
    e.so = pat(v % 10);
    e.st = (v / 10 == 0) ? 7'b1111111 : pat(v / 10);
    sb.push_back(e);
  endtask

  // sample one full scan (16 clk) plus margin
  task automatic check_scan(input string nm);
    exp_t e;
    logic [6:0] go, gt;
    bit so, st;
    int bad;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e  = sb.pop_front();
    so = 0;
    st = 0;
    bad = 0;
    go = 'x;
    gt = 'x;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.an === 4'b1110) begin
        go = bus.seg;
        so = 1;
      end else if (bus.an === 4'b1101) begin
        gt = bus.seg;
        st = 1;
      end else if (bus.an !== 4'b1111 ||
                   bus.seg !== 7'b1111111) begin
        bad++;
      end
    end
    n_checks++;
    if (!so || go !== e.so) begin
      n_fail++;
      $display("FAIL %s ones: got %b want %b seen=%0d",
               nm, go, e.so, so);
    end
    n_checks++;
    if (!st || gt !== e.st) begin
      n_fail++;
      $display("FAIL %s tens: got %b want %b seen=%0d",
               nm, gt, e.st, st);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s idle_slots: got %0d bad want 0",
               nm, bad);
    end
  endtask

  task automatic chk_bcd(input string nm,
                         input int t, input int o);
    n_checks++;
    if (dut.u_bcd.tens !== 4'(t) ||
        dut.u_bcd.ones !== 4'(o)) begin
      n_fail++;
      $display("FAIL %s: got %0d%0d want %0d%0d", nm,
               dut.u_bcd.tens, dut.u_bcd.ones, t, o);
    end
  endtask

  // change count after an edge, check old at +6 and new at +7
  task automatic convert(input string nm, input int v,
                         input int old_v);
    @(posedge clk);
    #1;
    bus.count_in = 5'(v);
    push_exp(v);
    repeat (6) @(posedge clk);
    #1;
    chk_bcd({nm, "_hold"}, old_v / 10, old_v % 10);
    @(posedge clk);
    #1;
    chk_bcd({nm, "_lat7"}, v / 10, v % 10);
    check_scan(nm);
  endtask

  task automatic test_reset();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111 ||
          bus.dp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold: got an=%b seg=%b dp=%b want 1111 1111111 1",
                 bus.an, bus.seg, bus.dp);
      end
    end
    reset = 0;
    @(negedge clk);
    n_checks++;
    if (bus.an !== 4'b1110 || bus.seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_first_slot: got an=%b seg=%b want 1110 1000000",
               bus.an, bus.seg);
    end
    push_exp(0);
    check_scan("reset_scan");
  endtask

  task automatic test_convert();
    convert("c17", 17, 0);
    convert("c29", 29, 17);
  endtask

  task automatic test_wrap();
    convert("wrap0", 0, 29);
  endtask

  task automatic test_midchange();
    int bad;
    convert("c05", 5, 0);
    bad = 0;
    @(posedge clk);
    #1;
    bus.count_in = 5'd23;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.count_in = 5'd9;
      if (i == 6) chk_bcd("mid_hold5", 0, 5);
      if (i == 7) chk_bcd("mid_23", 2, 3);
      if (i == 14) chk_bcd("mid_09", 0, 9);
      @(negedge clk);
      if (bus.an === 4'b1110 && bus.seg !== pat(5) &&
          bus.seg !== pat(3) && bus.seg !== pat(9))
        bad++;
      if (bus.an === 4'b1101 && bus.seg !== pat(2) &&
          bus.seg !== 7'b1111111)
        bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_glitch: got %0d corrupt want 0", bad);
    end
    push_exp(9);
    check_scan("mid_scan");
  endtask

  task automatic test_max();
    convert("c31", 31, 9);
    convert("c30", 30, 31);
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    bus.count_in = 5'd12;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    chk_bcd("rstmid_bcd", 0, 0);
    n_checks++;
    if (bus.an !== 4'b1111 || bus.seg !== 7'b1111111) begin
      n_fail++;
      $display("FAIL rstmid_out: got an=%b seg=%b want 1111 1111111",
               bus.an, bus.seg);
    end
    push_exp(12);
    repeat (10) @(posedge clk);
    check_scan("rstmid_scan");
  endtask

`ifdef SEG_BLINK_EN
  task automatic test_blink();
    logic [3:0] ea;
    int s;
    bus.game_start = 1;
    bus.game_on    = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int k = 1; k <= 96; k++) begin
      if (k == 65) bus.game_on = 1;
      @(negedge clk);
      s = ((k - 1) % 16) / 4;
      ea = (s == 0) ? 4'b1110 : (s == 1) ? 4'b1101 : 4'b1111;
      if (k <= 64 && (k % 32) >= 16) ea = 4'b1111;
      n_checks++;
      if (bus.an !== ea) begin
        n_fail++;
        $display("FAIL blink k=%0d: got an=%b want %b",
                 k, bus.an, ea);
      end
    end
    bus.game_start = 0;
    bus.game_on    = 0;
  endtask
`endif

  initial begin
    clk            = 0;
    reset          = 1;
    n_checks       = 0;
    n_fail         = 0;
    bus.count_in   = '0;
    bus.game_start = 0;
    bus.game_on    = 0;
    test_reset();
    test_convert();
    test_wrap();
    test_midchange();
    test_max();
    test_reset_mid();
`ifdef SEG_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
